// File: rtl/timer_pkg.sv
// Shared state encoding and round-robin helper for timer_sched and other
// round-robin arbiters.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RR_MAX_N = 16;
  localparam int RR_IDX_W = 4;

  // Returns 1 when some req bit is set. idx is the first asserted bit at or
  // after ptr, wrapping modulo n. Only the low n bits of req take part.
  function automatic logic rr_pick(
    input  logic [RR_IDX_W-1:0] ptr,
    input  logic [RR_MAX_N-1:0] req,
    input  int                  n,
    output logic [RR_IDX_W-1:0] idx
  );
    logic              found;
    logic [RR_IDX_W:0] j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      j = {1'b0, ptr} + (RR_IDX_W + 1)'(i);
      if (j >= (RR_IDX_W + 1)'(n)) begin
        j = j - (RR_IDX_W + 1)'(n);
      end
      if (!found && (i < n) && req[j[RR_IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[RR_IDX_W-1:0];
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/timer_sched_countdown.sv
// Countdown block: loads on put, decrements to zero and holds there.
// A clear has lower priority than put.
module timer_sched_countdown #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         put,
  input  logic [W-1:0] put_value,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (put) begin
      count_d = put_value;
    end else if (clear) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_sched.sv
// Round-robin sharing of one countdown timer between N requesters.
// Optional macro TIMER_SCHED_CANCEL_EN adds a per-requester cancel input.
module timer_sched
  import timer_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] value,
`ifdef TIMER_SCHED_CANCEL_EN
  input  logic [N-1:0]   cancel,
`endif
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [IW-1:0]  owner
);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [RR_IDX_W-1:0] pick_idx;
  logic                pick_found;
  logic [IW-1:0]       pick_k;
  logic [W-1:0]        pick_value;

  logic         cd_put;
  logic [W-1:0] cd_put_value;
  logic         cd_clear;
  logic [W-1:0] count;
  logic         expire;
  logic         cancel_hit;

  // A count of 1 means the delay elapses on this edge.
  assign expire = (count == W'(1));

`ifdef TIMER_SCHED_CANCEL_EN
  assign cancel_hit = cancel[owner_q];
`else
  assign cancel_hit = 1'b0;
`endif

  always_comb begin
    pick_idx     = '0;
    pick_found   = rr_pick(RR_IDX_W'(ptr_q), RR_MAX_N'(req), N, pick_idx);
    pick_k       = IW'(pick_idx);
    pick_value   = value[int'(pick_k)*W +: W];

    state_d      = state_q;
    grant_d      = '0;
    done_d       = '0;
    busy_d       = busy_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cd_put       = 1'b0;
    cd_put_value = '0;
    cd_clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d[pick_k] = 1'b1;
          owner_d         = pick_k;
          busy_d          = 1'b1;
          state_d         = ST_RUN;
          cd_put          = 1'b1;
          // A zero delay behaves like a one-cycle delay.
          cd_put_value    = (pick_value == '0) ? W'(1) : pick_value;
          ptr_d           = (pick_k == IW'(N - 1)) ? '0 : pick_k + 1'b1;
        end
      end
      ST_RUN: begin
        if (expire) begin
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          state_d         = ST_IDLE;
        end else if (cancel_hit) begin
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
          cd_clear = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  timer_sched_countdown #(.W(W)) u_countdown (
    .clock     (clock),
    .reset     (reset),
    .put       (cd_put),
    .put_value (cd_put_value),
    .clear     (cd_clear),
    .count     (count)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: a time-stamped reference model predicts
// every grant/done pulse, and a negedge monitor matches them against the DUT.
module tb_timer_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] value;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [IW-1:0]  owner;
`ifdef TIMER_SCHED_CANCEL_EN
  logic [N-1:0]   cancel;
`endif

  always #5 clock = ~clock;

  timer_sched #(.N(N), .W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .value  (value),
`ifdef TIMER_SCHED_CANCEL_EN
    .cancel (cancel),
`endif
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .owner  (owner)
  );

  typedef struct {
    bit is_done;
    int idx;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks    = 0;
  int  failures  = 0;
  int  edge_cnt  = 0;
  bit  mon_en    = 1'b0;
  bit  auto_drop = 1'b1;

  // Reference model: the timer is described by the absolute edge at which
  // its done pulse is due, not by a counter.
  bit m_run     = 1'b0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_done_at = 0;
  int m_gnt_now = -1;

  task automatic model_step();
    m_gnt_now = -1;
    if (reset) begin
      m_run   = 1'b0;
      m_ptr   = 0;
      m_owner = 0;
    end else if (m_run) begin
      if (edge_cnt == m_done_at) begin
        exp_q.push_back('{1'b1, m_owner, edge_cnt});
        m_run = 1'b0;
      end
    end else if (req != '0) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (req[j] && m_gnt_now < 0) m_gnt_now = j;
      end
      begin
        int v;
        v         = int'(value[m_gnt_now*W +: W]);
        m_done_at = edge_cnt + ((v == 0) ? 1 : v);
      end
      exp_q.push_back('{1'b0, m_gnt_now, edge_cnt});
      m_owner = m_gnt_now;
      m_ptr   = (m_gnt_now + 1) % N;
      m_run   = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    edge_cnt++;
    model_step();
    @(negedge clock);
    chk("busy", 32'(busy), 32'(m_run));
    chk("owner", 32'(owner), 32'(m_owner));
    if (auto_drop && m_gnt_now >= 0) req[m_gnt_now] = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_check();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
  endtask

  task automatic set_req(input int i, input int v);
    req[i]           = 1'b1;
    value[i*W +: W]  = W'(v);
  endtask

  task automatic match(input bit is_done, input logic [N-1:0] vec);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s at edge %0d: got %b expected none",
               is_done ? "done" : "grant", edge_cnt, vec);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || vec != (N'(1) << e.idx) || e.cyc != edge_cnt) begin
        failures++;
        $display("FAIL %s_event at edge %0d: got %b expected %s %0d at edge %0d",
                 is_done ? "done" : "grant", edge_cnt, vec,
                 e.is_done ? "done" : "grant", e.idx, e.cyc);
      end else begin
        $display("ok %s %0d at edge %0d", is_done ? "done" : "grant", e.idx, edge_cnt);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL missed_event: got nothing expected %s %0d at edge %0d",
                 exp_q[0].is_done ? "done" : "grant", exp_q[0].idx, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      checks++;
      if (!$onehot0(grant) || !$onehot0(done) || (grant != '0 && done != '0)) begin
        failures++;
        $display("FAIL pulse_shape at edge %0d: got grant=%b done=%b expected onehot0 and exclusive",
                 edge_cnt, grant, done);
      end
      if (grant != '0) match(1'b0, grant);
      if (done != '0) match(1'b1, done);
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    value = '0;
`ifdef TIMER_SCHED_CANCEL_EN
    cancel = '0;
`endif
    ticks(2);
    reset_check();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single request, value 5.
    set_req(0, 5);
    ticks(9);

    // Round-robin with all requests held.
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 2);
    ticks(22);
    req = '0;
    ticks(4);
    auto_drop = 1'b1;

    // Zero delay, then maximum delay with others waiting.
    set_req(0, 0);
    ticks(4);
    set_req(0, 255);
    tick();
    for (int i = 1; i < N; i++) set_req(i, 3);
    ticks(258);
    ticks(20);
    req = '0;
    ticks(4);

    // Reset in the middle of a delay, then a fresh request.
    set_req(2, 10);
    ticks(5);
    reset = 1'b1;
    req   = '0;
    tick();
    reset_check();
    reset = 1'b0;
    ticks(12);
    set_req(2, 10);
    ticks(14);

    // Withdrawal of a waiting request.
    set_req(0, 6);
    ticks(2);
    set_req(1, 3);
    tick();
    req[1] = 1'b0;
    ticks(10);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(99) < 20)
            set_req(i, ($urandom_range(99) < 3) ? 255 : int'($urandom_range(12)));
          else
            value[i*W +: W] = W'($urandom);
        end else if ($urandom_range(99) < 3) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(999) < 2) begin
        reset = 1'b1;
        tick();
        reset_check();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    req = '0;
    ticks(300);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
